// File: rtl/sd_img_sched.sv
// Whole-image sector scheduler for the shared SD controller port: arbitrates save/read
// requests and issues one start pulse per sector with incrementing addresses.
module sd_img_sched #(
    parameter int          SEC_WORDS   = 256,
    parameter int          IMG_SECTORS = 1200,
    parameter logic [31:0] WR_BASE     = 32'd20000,
    parameter logic [31:0] RD_BASE     = 32'd20000,
    parameter int          LEN_W       = 10
) (
    input  logic             SD_clk_ref,
    input  logic             sys_rst_n,
    input  logic             sd_init_done,
    input  logic             save_req,
    input  logic             read_req,
    input  logic [LEN_W-1:0] wr_fifo_len,
    input  logic             wr_busy,
    input  logic             rd_busy,
    output logic             wr_start_en,
    output logic [31:0]      wr_sec_addr,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic             wr_img_done,
    output logic             rd_img_done,
    output logic             sched_busy,
    output logic [15:0]      sec_cnt,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_GO   = 3'd2,
        WR_RUN  = 3'd3,
        RD_GO   = 3'd4,
        RD_RUN  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [LEN_W:0] SEC_WORDS_W = (LEN_W+1)'(SEC_WORDS);
    localparam logic [15:0]    IMG_SEC_W   = 16'(IMG_SECTORS);

    state_t      state_reg, state_next;
    logic [2:0]  save_sync_reg, read_sync_reg;
    logic        init_d_reg;
    logic        wr_pend_reg, wr_pend_next;
    logic        rd_pend_reg, rd_pend_next;
    logic        is_wr_reg, is_wr_next;
    logic [15:0] sec_cnt_reg, sec_cnt_next;
    logic [31:0] wr_addr_reg, wr_addr_next;
    logic [31:0] rd_addr_reg, rd_addr_next;
    logic        wr_start_reg, wr_start_next;
    logic        rd_start_reg, rd_start_next;
    logic [5:0]  wdog_reg, wdog_next;

    logic        save_rise, read_rise, wr_active, rd_active, wr_req, rd_req;
    logic        fifo_ok, init_fall, last_sec;
    logic [15:0] sec_inc;

    always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            save_sync_reg <= 3'b000;
            read_sync_reg <= 3'b000;
            init_d_reg    <= 1'b0;
            wr_pend_reg   <= 1'b0;
            rd_pend_reg   <= 1'b0;
            is_wr_reg     <= 1'b0;
            sec_cnt_reg   <= 16'd0;
            wr_addr_reg   <= WR_BASE;
            rd_addr_reg   <= RD_BASE;
            wr_start_reg  <= 1'b0;
            rd_start_reg  <= 1'b0;
            wdog_reg      <= 6'd0;
        end else begin
            state_reg     <= state_next;
            save_sync_reg <= {save_sync_reg[1:0], save_req};
            read_sync_reg <= {read_sync_reg[1:0], read_req};
            init_d_reg    <= sd_init_done;
            wr_pend_reg   <= wr_pend_next;
            rd_pend_reg   <= rd_pend_next;
            is_wr_reg     <= is_wr_next;
            sec_cnt_reg   <= sec_cnt_next;
            wr_addr_reg   <= wr_addr_next;
            rd_addr_reg   <= rd_addr_next;
            wr_start_reg  <= wr_start_next;
            rd_start_reg  <= rd_start_next;
            wdog_reg      <= wdog_next;
        end
    end

    always_comb begin
        save_rise = save_sync_reg[1] & ~save_sync_reg[2];
        read_rise = read_sync_reg[1] & ~read_sync_reg[2];
        wr_active = (state_reg == WR_WAIT) || (state_reg == WR_GO) || (state_reg == WR_RUN);
        rd_active = (state_reg == RD_GO) || (state_reg == RD_RUN);
        // A new edge for the image type already in flight is absorbed; the other type is held.
        wr_req    = wr_pend_reg | (save_rise & ~wr_active);
        rd_req    = rd_pend_reg | (read_rise & ~rd_active);
        fifo_ok   = {1'b0, wr_fifo_len} >= SEC_WORDS_W;
        init_fall = init_d_reg & ~sd_init_done;
        sec_inc   = sec_cnt_reg + 16'd1;
        last_sec  = (sec_inc == IMG_SEC_W);

        state_next    = state_reg;
        wr_pend_next  = wr_req;
        rd_pend_next  = rd_req;
        is_wr_next    = is_wr_reg;
        sec_cnt_next  = sec_cnt_reg;
        wr_addr_next  = wr_addr_reg;
        rd_addr_next  = rd_addr_reg;
        wr_start_next = 1'b0;
        rd_start_next = 1'b0;
        wdog_next     = 6'd0;

        case (state_reg)
            IDLE: begin
                if (wr_req) begin
                    state_next   = WR_WAIT;
                    wr_pend_next = 1'b0;
                    is_wr_next   = 1'b1;
                    sec_cnt_next = 16'd0;
                    wr_addr_next = WR_BASE;
                end else if (rd_req && !rd_busy) begin
                    state_next    = RD_GO;
                    rd_pend_next  = 1'b0;
                    is_wr_next    = 1'b0;
                    sec_cnt_next  = 16'd0;
                    rd_addr_next  = RD_BASE;
                    rd_start_next = 1'b1;
                end
            end
            WR_WAIT: begin
                if (fifo_ok && !wr_busy) begin
                    state_next    = WR_GO;
                    wr_start_next = 1'b1;
                end
            end
            WR_GO: begin
                if (wr_busy)
                    state_next = WR_RUN;
                else if (wdog_reg == 6'd63)
                    state_next = IDLE;
                else
                    wdog_next = wdog_reg + 6'd1;
            end
            WR_RUN: begin
                if (!wr_busy) begin
                    sec_cnt_next = sec_inc;
                    wr_addr_next = wr_addr_reg + 32'd1;
                    state_next   = last_sec ? DONE : WR_WAIT;
                end
            end
            RD_GO: begin
                if (rd_busy)
                    state_next = RD_RUN;
                else if (wdog_reg == 6'd63)
                    state_next = IDLE;
                else
                    wdog_next = wdog_reg + 6'd1;
            end
            RD_RUN: begin
                if (!rd_busy) begin
                    sec_cnt_next = sec_inc;
                    rd_addr_next = rd_addr_reg + 32'd1;
                    if (last_sec) begin
                        state_next = DONE;
                    end else begin
                        state_next    = RD_GO;
                        rd_start_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Losing the card overrides everything: park in IDLE without issuing any pulse.
        if (!sd_init_done) begin
            state_next    = IDLE;
            wr_start_next = 1'b0;
            rd_start_next = 1'b0;
            wdog_next     = 6'd0;
        end
        if (init_fall) begin
            wr_pend_next = 1'b0;
            rd_pend_next = 1'b0;
        end
    end

    assign wr_start_en = wr_start_reg;
    assign rd_start_en = rd_start_reg;
    assign wr_sec_addr = wr_addr_reg;
    assign rd_sec_addr = rd_addr_reg;
    assign wr_img_done = (state_reg == DONE) && is_wr_reg;
    assign rd_img_done = (state_reg == DONE) && !is_wr_reg;
    assign sched_busy  = (state_reg != IDLE);
    assign sec_cnt     = sec_cnt_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_sd_img_sched.sv
// Directed bench for sd_img_sched with a 4-sector image and a simple controller model.
module tb_sd_img_sched;

    logic        SD_clk_ref = 1'b0;
    logic        sys_rst_n, sd_init_done, save_req, read_req;
    logic [9:0]  wr_fifo_len;
    logic        wr_busy, rd_busy;
    logic        wr_start_en, rd_start_en, wr_img_done, rd_img_done, sched_busy;
    logic [31:0] wr_sec_addr, rd_sec_addr;
    logic [15:0] sec_cnt;
    logic [2:0]  state_o;
    logic        ctl_en;

    always #5 SD_clk_ref = ~SD_clk_ref;

    sd_img_sched #(.IMG_SECTORS(4)) dut (
        .SD_clk_ref  (SD_clk_ref),
        .sys_rst_n   (sys_rst_n),
        .sd_init_done(sd_init_done),
        .save_req    (save_req),
        .read_req    (read_req),
        .wr_fifo_len (wr_fifo_len),
        .wr_busy     (wr_busy),
        .rd_busy     (rd_busy),
        .wr_start_en (wr_start_en),
        .wr_sec_addr (wr_sec_addr),
        .rd_start_en (rd_start_en),
        .rd_sec_addr (rd_sec_addr),
        .wr_img_done (wr_img_done),
        .rd_img_done (rd_img_done),
        .sched_busy  (sched_busy),
        .sec_cnt     (sec_cnt),
        .state_o     (state_o)
    );

    int total = 0;
    int bad   = 0;
    int cycn = 0, wr_starts = 0, rd_starts = 0, wr_dones = 0, rd_dones = 0, wr_done_cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];

    task automatic cyc(input int n);
        repeat (n) @(negedge SD_clk_ref);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return wr_starts;
            1:       return rd_starts;
            2:       return wr_dones;
            default: return rd_dones;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int limit, input string tag);
        int n = 0;
        while (cnt_of(which) < target && n < limit) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(cnt_of(which) >= target), 32'd1);
    endtask

    task automatic pulse_req(input logic s, input logic r);
        save_req = s;
        read_req = r;
        cyc(3);
        save_req = 1'b0;
        read_req = 1'b0;
    endtask

    // Controller model: busy rises one cycle after a start pulse and stays high 20 cycles.
    initial begin
        wr_busy = 1'b0;
        forever begin
            @(negedge SD_clk_ref);
            if (wr_start_en === 1'b1 && ctl_en) begin
                @(negedge SD_clk_ref);
                wr_busy = 1'b1;
                cyc(20);
                wr_busy = 1'b0;
            end
        end
    end

    initial begin
        rd_busy = 1'b0;
        forever begin
            @(negedge SD_clk_ref);
            if (rd_start_en === 1'b1 && ctl_en) begin
                @(negedge SD_clk_ref);
                rd_busy = 1'b1;
                cyc(20);
                rd_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge SD_clk_ref);
            cycn++;
            if (wr_start_en === 1'b1) begin
                wr_starts++;
                wr_addr_q.push_back(wr_sec_addr);
                $display("t=%0t wr_start addr=%0d", $time, wr_sec_addr);
            end
            if (rd_start_en === 1'b1) begin
                rd_starts++;
                rd_addr_q.push_back(rd_sec_addr);
                rd_cyc_q.push_back(cycn);
                $display("t=%0t rd_start addr=%0d", $time, rd_sec_addr);
            end
            if (wr_img_done === 1'b1) begin
                wr_dones++;
                wr_done_cyc = cycn;
                $display("t=%0t wr_img_done sec_cnt=%0d", $time, sec_cnt);
            end
            if (rd_img_done === 1'b1) begin
                rd_dones++;
                $display("t=%0t rd_img_done sec_cnt=%0d", $time, sec_cnt);
            end
        end
    end

    initial begin
        int s_ws, s_rs, s_wd, s_rd, wi, ri, n;
        sys_rst_n    = 1'b0;
        sd_init_done = 1'b0;
        save_req     = 1'b0;
        read_req     = 1'b0;
        wr_fifo_len  = 10'd0;
        ctl_en       = 1'b1;
        cyc(3);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_wr_start", 32'(wr_start_en), 32'd0);
        check("rst_busy", 32'(sched_busy), 32'd0);
        check("rst_wr_addr", wr_sec_addr, 32'd20000);
        check("rst_rd_addr", rd_sec_addr, 32'd20000);
        check("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        sys_rst_n = 1'b1;
        cyc(2);

        // 1: basic 4-sector write image
        sd_init_done = 1'b1;
        wr_fifo_len  = 10'd300;
        s_ws = wr_starts; s_wd = wr_dones; wi = wr_addr_q.size();
        pulse_req(1'b1, 1'b0);
        wait_cnt(2, s_wd + 1, 400, "t1_done_wait");
        check("t1_starts", 32'(wr_starts - s_ws), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t1_addr", wr_addr_q[wi + i], 32'd20000 + 32'(i));
        cyc(3);
        check("t1_sec_cnt", 32'(sec_cnt), 32'd4);
        check("t1_dones", 32'(wr_dones - s_wd), 32'd1);
        check("t1_idle", 32'(state_o), 32'd0);

        // 2: FIFO gating at 255/256
        wr_fifo_len = 10'd255;
        s_ws = wr_starts; s_wd = wr_dones;
        pulse_req(1'b1, 1'b0);
        cyc(30);
        check("t2_no_start", 32'(wr_starts - s_ws), 32'd0);
        check("t2_wait_state", 32'(state_o), 32'd1);
        wr_fifo_len = 10'd256;
        n = 0;
        while (wr_start_en !== 1'b1 && n < 4) begin
            cyc(1);
            n++;
        end
        check("t2_latency", 32'(wr_start_en === 1'b1 && n <= 2), 32'd1);
        wait_cnt(2, s_wd + 1, 400, "t2_done_wait");

        // 3: simultaneous save and read, write first
        s_wd = wr_dones; s_rd = rd_dones; s_rs = rd_starts; ri = rd_addr_q.size();
        pulse_req(1'b1, 1'b1);
        wait_cnt(3, s_rd + 1, 1000, "t3_rd_done_wait");
        check("t3_wr_dones", 32'(wr_dones - s_wd), 32'd1);
        check("t3_rd_dones", 32'(rd_dones - s_rd), 32'd1);
        check("t3_rd_starts", 32'(rd_starts - s_rs), 32'd4);
        check("t3_rd_addr0", rd_addr_q[ri], 32'd20000);
        check("t3_rd_addr3", rd_addr_q[ri + 3], 32'd20003);
        check("t3_order", 32'(rd_cyc_q[ri] > wr_done_cyc), 32'd1);

        // 4: read held during write; repeated save absorbed
        s_ws = wr_starts; s_wd = wr_dones; s_rd = rd_dones; ri = rd_addr_q.size();
        pulse_req(1'b1, 1'b0);
        wait_cnt(0, s_ws + 2, 200, "t4_sec2_wait");
        pulse_req(1'b1, 1'b1);
        wait_cnt(3, s_rd + 1, 1000, "t4_rd_done_wait");
        cyc(60);
        check("t4_wr_dones", 32'(wr_dones - s_wd), 32'd1);
        check("t4_wr_starts", 32'(wr_starts - s_ws), 32'd4);
        check("t4_rd_dones", 32'(rd_dones - s_rd), 32'd1);
        check("t4_order", 32'(rd_cyc_q[ri] > wr_done_cyc), 32'd1);
        check("t4_idle", 32'(state_o), 32'd0);

        // 5: init_done drop in WR_RUN
        s_ws = wr_starts; s_wd = wr_dones;
        pulse_req(1'b1, 1'b0);
        n = 0;
        while (state_o !== 3'd3 && n < 100) begin
            cyc(1);
            n++;
        end
        check("t5_reach_run", 32'(state_o), 32'd3);
        sd_init_done = 1'b0;
        cyc(1);
        check("t5_idle_next", 32'(state_o), 32'd0);
        check("t5_not_busy", 32'(sched_busy), 32'd0);
        cyc(60);
        check("t5_starts", 32'(wr_starts - s_ws), 32'd1);
        check("t5_no_done", 32'(wr_dones - s_wd), 32'd0);
        sd_init_done = 1'b1;
        cyc(5);
        check("t5_stay_idle", 32'(state_o), 32'd0);

        // 6a: watchdog abort when busy never rises
        ctl_en = 1'b0;
        s_wd = wr_dones;
        save_req = 1'b1;
        n = 0;
        while (wr_start_en !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check("t6_start_seen", 32'(wr_start_en), 32'd1);
        n = 0;
        while (state_o !== 3'd0 && n < 100) begin
            cyc(1);
            n++;
        end
        check("t6_abort_cycles", 32'(n), 32'd64);
        save_req = 1'b0;
        cyc(5);
        check("t6_no_done", 32'(wr_dones - s_wd), 32'd0);
        ctl_en = 1'b1;

        // 6b: async reset mid-image
        s_ws = wr_starts; s_wd = wr_dones;
        pulse_req(1'b1, 1'b0);
        wait_cnt(0, s_ws + 2, 200, "t6_sec2_wait");
        cyc(5);
        check("t6_pre_sec_cnt", 32'(sec_cnt), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(state_o), 32'd0);
        check("t6_rst_busy", 32'(sched_busy), 32'd0);
        check("t6_rst_addr", wr_sec_addr, 32'd20000);
        check("t6_rst_sec_cnt", 32'(sec_cnt), 32'd0);
        check("t6_rst_start", 32'(wr_start_en), 32'd0);
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(60);
        check("t6_post_starts", 32'(wr_starts - s_ws), 32'd2);
        check("t6_post_done", 32'(wr_dones - s_wd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
